// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Covers the stall bus layout, exception codes and controller state encodings.
package pipeline_ctrl_pkg;

   localparam int STALL_W = 6;
   typedef logic [STALL_W-1:0] stall_bus_t;

   localparam logic STOP   = 1'b1;
   localparam logic NOSTOP = 1'b0;

   localparam int EXC_CODE_W = 5;
   typedef logic [EXC_CODE_W-1:0] exc_code_t;

   localparam exc_code_t EXC_INT  = 5'h00;
   localparam exc_code_t EXC_ADEL = 5'h04;
   localparam exc_code_t EXC_ADES = 5'h05;
   localparam exc_code_t EXC_IBE  = 5'h06;
   localparam exc_code_t EXC_DBE  = 5'h07;
   localparam exc_code_t EXC_SYS  = 5'h08;
   localparam exc_code_t EXC_BP   = 5'h09;
   localparam exc_code_t EXC_RI   = 5'h0a;
   localparam exc_code_t EXC_OV   = 5'h0c;
   // Codes above the architectural range mark "no exception" and ERET.
   localparam exc_code_t EXC_NONE = 5'h10;
   localparam exc_code_t EXC_ERET = 5'h11;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_RECOVER = 2'd1,
      ST_TMO     = 2'd2
   } state_t;

   // Thermometer stall: the requesting stage and every stage behind it stop.
   function automatic stall_bus_t stall_mask(input logic req_id,
                                             input logic req_exe,
                                             input logic req_mem);
      stall_bus_t s;
      s = {STALL_W{NOSTOP}};
      if (req_mem) begin
         s[4:0] = {5{STOP}};
      end else if (req_exe) begin
         s[3:0] = {4{STOP}};
      end else if (req_id) begin
         s[2:0] = {3{STOP}};
      end
      return s;
   endfunction

   // A delay-slot instruction reports its branch as the restart point.
   function automatic logic [31:0] exc_epc(input logic [31:0] pc,
                                           input logic        in_delay);
      return in_delay ? (pc - 32'd4) : pc;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_mem_wait_timer.sv
// Saturating counter of consecutive data-bus wait cycles with a terminal flag.
// Holds at MEM_TIMEOUT-1 instead of wrapping; clear has priority over increment.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = $clog2(MEM_TIMEOUT)
) (
   input  logic cpu_clk_50M,
   input  logic cpu_rst,
   input  logic inc,
   input  logic clr,
   output logic terminal
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(MEM_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != TERM)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign terminal = (cnt == TERM);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush generator: merges stage stall requests with MEM-stage
// exceptions/ERET, supervises data-bus waits and drives the CP0 exception record.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int          MEM_TIMEOUT = 16,
   parameter logic [31:0] EXC_ENTRY   = 32'hBFC00380
) (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst,
   input  logic        stallreq_id,
   input  logic        stallreq_exe,
   input  logic        stallreq_mem,
   input  exc_code_t   mem_exccode,
   input  logic [31:0] mem_pc,
   input  logic        mem_in_delay,
   input  logic [31:0] cp0_epc,
   output stall_bus_t  stall,
   output logic        flush,
   output logic [31:0] flush_pc,
   output logic        cp0_exc_we,
   output exc_code_t   cp0_exc_code,
   output logic [31:0] cp0_exc_epc,
   output logic        cp0_exc_bd,
   output state_t      dbg_state
);

   state_t state;
   logic   exc_present;
   logic   is_eret;
   logic   tmr_inc;
   logic   tmr_clr;
   logic   tmr_terminal;

   assign exc_present = (mem_exccode != EXC_NONE);
   assign is_eret     = (mem_exccode == EXC_ERET);

   // Only plain RUN-state bus waits count toward the timeout.
   assign tmr_inc = (state == ST_RUN) && !exc_present && stallreq_mem;
   assign tmr_clr = !tmr_inc;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_wait_timer (
      .cpu_clk_50M (cpu_clk_50M),
      .cpu_rst     (cpu_rst),
      .inc         (tmr_inc),
      .clr         (tmr_clr),
      .terminal    (tmr_terminal)
   );

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         state <= ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               if (exc_present) begin
                  state <= ST_RECOVER;
               end else if (stallreq_mem && tmr_terminal) begin
                  state <= ST_TMO;
               end
            end
            ST_TMO:     state <= ST_RECOVER;
            ST_RECOVER: state <= ST_RUN;
            default:    state <= ST_RUN;
         endcase
      end
   end

   assign dbg_state = state;

   // Reset forces every output low, even while leaving TMO or RECOVER.
   always_comb begin
      stall        = '0;
      flush        = 1'b0;
      flush_pc     = 32'd0;
      cp0_exc_we   = 1'b0;
      cp0_exc_code = '0;
      cp0_exc_epc  = 32'd0;
      cp0_exc_bd   = 1'b0;
      if (!cpu_rst) begin
         case (state)
            ST_RUN: begin
               if (exc_present) begin
                  flush        = 1'b1;
                  flush_pc     = is_eret ? cp0_epc : EXC_ENTRY;
                  cp0_exc_we   = !is_eret;
                  cp0_exc_code = mem_exccode;
                  cp0_exc_epc  = exc_epc(mem_pc, mem_in_delay);
                  cp0_exc_bd   = mem_in_delay;
               end else begin
                  stall = stall_mask(stallreq_id, stallreq_exe, stallreq_mem);
               end
            end
            ST_TMO: begin
               flush        = 1'b1;
               flush_pc     = EXC_ENTRY;
               cp0_exc_we   = 1'b1;
               cp0_exc_code = EXC_DBE;
               cp0_exc_epc  = exc_epc(mem_pc, mem_in_delay);
               cp0_exc_bd   = mem_in_delay;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
